hfrv_mem_arbiter: RTL and testbench

- Two-master, single-outstanding arbiter that shares one synchronous single-port memory.
- Master 0 is the hf-riscv core data port; master 1 is the bench/DMA loader port.
- Sequences each access as issue → fixed-latency wait → response, and grants masters by round-robin or fixed priority.
- Sits between dut core memory ports and the shared RAM model instantiated under dut_top.

---
 rtl/hfrv_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_hfrv_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_mem_arbiter.sv
// Two-master, single-outstanding arbiter in front of one synchronous single-port
// memory with a fixed read latency; round-robin or fixed-priority grant.
//
// state | meaning
// IDLE  | no access in flight, arbitrating every cycle
// ISSUE | memory strobe and owner grant driven for one cycle
// WAIT  | counting down the memory latency, capture read data at zero
// RESP  | owner rvalid pulse; arbitrates again for back-to-back access
module hfrv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_we,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W/8-1:0]   m1_we,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
  localparam logic       FIXED    = (FIXED_PRIO != 0);

  logic [1:0] state;
  logic       owner;
  logic       ptr;    // master that wins the next tie under round-robin
  logic [3:0] cnt;

  logic                any_req;
  logic                win;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W/8-1:0] win_we;
  logic [DATA_W-1:0]   win_wdata;

  always_comb begin
    any_req   = m0_req | m1_req;
    win       = m1_req & (~m0_req | (~FIXED & ptr));
    win_addr  = win ? m1_addr  : m0_addr;
    win_we    = win ? m1_we    : m0_we;
    win_wdata = win ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      cnt       <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state     <= ISSUE;
            owner     <= win;
            mem_en    <= 1'b1;
            mem_addr  <= win_addr;
            mem_we    <= win_we;
            mem_wdata <= win_wdata;
            m0_gnt    <= ~win;
            m1_gnt    <= win;
            busy      <= 1'b1;
          end else begin
            state  <= IDLE;
            mem_we <= '0;
            busy   <= 1'b0;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          mem_we <= '0;
          ptr    <= ~owner;
          cnt    <= LAT_LOAD;
          busy   <= 1'b1;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // writes take the same path; the captured word is don't-care
            state <= RESP;
            busy  <= 1'b0;
            if (owner) begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Random two-master traffic against hfrv_mem_arbiter in four latency/priority
// configurations, compared every cycle with a transaction-timing reference model.
module tb_hfrv_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic contend = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'hDEAD_BEEF : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int LAT = (g == 1) ? 3 : ((g == 3) ? 15 : 1);
    localparam int FP  = (g == 2) ? 1 : 0;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] addr  [2];
    logic [3:0]  we    [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        mem_en;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_we;
    logic [31:0] ram  [256];
    logic [31:0] pipe [LAT];

    hfrv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .FIXED_PRIO(FP)) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_addr(addr[0]), .m0_we(we[0]), .m0_wdata(wdata[0]),
      .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
      .m1_req(req[1]), .m1_addr(addr[1]), .m1_we(we[1]), .m1_wdata(wdata[1]),
      .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // memory: read data valid exactly LAT cycles after the strobe, garbage otherwise
    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      end else if (mem_en) begin
        ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_we);
      end
      pipe[0] <= mem_en ? ram[mem_addr[9:2]] : $urandom;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    initial begin : drv
      int          c;
      int          win;
      int          gnt_c;
      int          rv_c;
      int          next_arb;
      int          owner;
      int          last;
      logic [31:0] x_addr;
      logic [31:0] x_wdata;
      logic [3:0]  x_we;
      logic [31:0] p_data;
      logic        p_read;
      logic        rst_prev;
      logic        first0;
      logic [1:0]  known;
      logic [1:0]  pending;
      logic [31:0] rd [2];
      logic [31:0] shadow [256];

      gnt_c = -100; rv_c = -100; next_arb = 0; owner = 0; last = 1;
      x_addr = '0; x_wdata = '0; x_we = '0; p_data = '0; p_read = 1'b0;
      rst_prev = 1'b1; first0 = 1'b1; known = 2'b11; pending = 2'b00;
      rd[0] = '0; rd[1] = '0;
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      req = 2'b00;
      for (int m = 0; m < 2; m++) begin
        addr[m] = '0; we[m] = '0; wdata[m] = '0;
      end

      forever begin
        @(negedge clk);
        c = cyc;
        if (c == rv_c) begin
          rd[owner]    = p_data;
          known[owner] = p_read;
        end

        if (c >= 1) begin
          check($sformatf("cfg%0d m0_gnt", g),    32'(gnt[0]),    32'(c == gnt_c && owner == 0));
          check($sformatf("cfg%0d m1_gnt", g),    32'(gnt[1]),    32'(c == gnt_c && owner == 1));
          check($sformatf("cfg%0d m0_rvalid", g), 32'(rvalid[0]), 32'(c == rv_c && owner == 0));
          check($sformatf("cfg%0d m1_rvalid", g), 32'(rvalid[1]), 32'(c == rv_c && owner == 1));
          check($sformatf("cfg%0d mem_en", g),    32'(mem_en),    32'(c == gnt_c));
          check($sformatf("cfg%0d mem_we", g),    32'(mem_we),    (c == gnt_c) ? 32'(x_we) : 32'h0);
          check($sformatf("cfg%0d busy", g),      32'(busy),      32'(c >= gnt_c && c < rv_c));
          if (rst_prev) begin
            check($sformatf("cfg%0d mem_addr_rst", g),  mem_addr,  32'h0);
            check($sformatf("cfg%0d mem_wdata_rst", g), mem_wdata, 32'h0);
          end else if (c == gnt_c) begin
            check($sformatf("cfg%0d mem_addr", g),  mem_addr,  x_addr);
            check($sformatf("cfg%0d mem_wdata", g), mem_wdata, x_wdata);
          end
          if (known[0]) check($sformatf("cfg%0d m0_rdata", g), rdata[0], rd[0]);
          if (known[1]) check($sformatf("cfg%0d m1_rdata", g), rdata[1], rd[1]);
        end

        // masters: hold req until granted, then drop it or present the next access
        for (int m = 0; m < 2; m++) begin
          if (gnt[m]) begin
            pending[m] = 1'b0;
            req[m]     = 1'b0;
          end
          if (!pending[m] && (contend || $urandom_range(0, 3) == 0)) begin
            pending[m] = 1'b1;
            req[m]     = 1'b1;
            if (m == 0 && first0) begin
              addr[m] = 32'h100;
              we[m]   = 4'h0;
              first0  = 1'b0;
            end else begin
              addr[m] = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
              we[m]   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            wdata[m] = $urandom;
          end
        end

        // reference: what the edge closing this cycle does
        if (reset) begin
          gnt_c = -100; rv_c = -100; next_arb = c + 1; last = 1;
          rd[0] = '0; rd[1] = '0; known = 2'b11;
        end else if (c >= next_arb) begin
          if (req != 2'b00) begin
            if (req == 2'b11) win = (FP != 0) ? 0 : 1 - last;
            else              win = req[1] ? 1 : 0;
            last    = win;
            owner   = win;
            x_addr  = addr[win];
            x_we    = we[win];
            x_wdata = wdata[win];
            if (x_we == 4'h0) begin
              p_read = 1'b1;
              p_data = shadow[x_addr[9:2]];
            end else begin
              p_read = 1'b0;
              shadow[x_addr[9:2]] = merge(shadow[x_addr[9:2]], x_wdata, x_we);
            end
            gnt_c    = c + 1;
            rv_c     = c + 2 + LAT;
            next_arb = rv_c;
          end else begin
            next_arb = c + 1;
          end
        end
        rst_prev = reset;
      end
    end
  end

  initial begin
    reset   = 1'b1;
    contend = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (150) @(posedge clk);
    for (int p = 0; p < 12; p++) begin
      #2 contend = (p < 4) || (p >= 9);
      repeat ($urandom_range(20, 200)) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
    end
    repeat (300) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
